// File: rtl/pio_pkg.sv
// Shared definitions for the PIO edge poller: slave register map,
// poller states and the Avalon-MM command bundle.
package pio_pkg;

    localparam logic [1:0] PIO_DATA     = 2'd0;
    localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_CAP,
        ST_WT_CAP,
        ST_CLR,
        ST_RD_LVL,
        ST_WT_LVL
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [1:0]  address;
        logic [31:0] writedata;
    } avm_cmd_t;

    localparam avm_cmd_t AVM_IDLE = '{
        cs:        1'b0,
        write_n:   1'b1,
        address:   2'd0,
        writedata: 32'd0
    };

    function automatic avm_cmd_t avm_wr(
        input logic [1:0]  addr,
        input logic [31:0] data
    );
        avm_cmd_t c;
        c.cs        = 1'b1;
        c.write_n   = 1'b0;
        c.address   = addr;
        c.writedata = data;
        return c;
    endfunction

    function automatic avm_cmd_t avm_rd(input logic [1:0] addr);
        avm_cmd_t c;
        c.cs        = 1'b1;
        c.write_n   = 1'b1;
        c.address   = addr;
        c.writedata = 32'd0;
        return c;
    endfunction

endpackage

// File: rtl/pio_edge_poller.sv
// Polls an Avalon PIO slave for captured edges on a timer or irq,
// clears the capture, and reports events and the current input level.
module pio_edge_poller
    import pio_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1000,
    parameter bit          USE_IRQ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        irq,
    output logic        event_pulse,
    output logic        level,
    output logic [7:0]  event_count
);

    localparam logic [15:0] TIMER_LAST = 16'(POLL_PERIOD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [15:0] timer;
    avm_cmd_t   cmd;
    logic       pulse;
    logic       poll_due;
    logic       unused_rd;

    assign unused_rd = ^avm_readdata[31:1];

    assign poll_due = enable &&
        ((timer == TIMER_LAST) || (USE_IRQ && irq));

    always_comb begin
        state_nxt = state;
        cmd       = AVM_IDLE;
        pulse     = 1'b0;
        unique case (state)
            ST_INIT: begin
                cmd       = avm_wr(PIO_IRQ_MASK, {31'd0, USE_IRQ});
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (poll_due)
                    state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                cmd       = avm_rd(PIO_EDGE_CAP);
                state_nxt = ST_WT_CAP;
            end
            ST_WT_CAP: begin
                state_nxt = avm_readdata[0] ? ST_CLR : ST_RD_LVL;
            end
            ST_CLR: begin
                cmd       = avm_wr(PIO_EDGE_CAP, 32'd0);
                pulse     = 1'b1;
                state_nxt = ST_RD_LVL;
            end
            ST_RD_LVL: begin
                cmd       = avm_rd(PIO_DATA);
                state_nxt = ST_WT_LVL;
            end
            ST_WT_LVL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    // Timer only runs while resting in IDLE; wraps if polling is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= '0;
        else if (state != ST_IDLE || state_nxt != ST_IDLE)
            timer <= '0;
        else if (timer == TIMER_LAST)
            timer <= '0;
        else
            timer <= timer + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_count <= '0;
            level       <= 1'b0;
        end else begin
            if (state == ST_CLR)
                event_count <= event_count + 8'd1;
            if (state == ST_WT_LVL)
                level <= avm_readdata[0];
        end
    end

    // State sits in INIT during reset, so the bus is forced idle here.
    assign avm_chipselect = cmd.cs & reset_n;
    assign avm_write_n    = cmd.write_n | ~reset_n;
    assign avm_address    = cmd.address & {2{reset_n}};
    assign avm_writedata  = cmd.writedata & {32{reset_n}};
    assign event_pulse    = pulse & reset_n;

endmodule

// File: tb/tb_pio_edge_poller.sv
// Bench for pio_edge_poller: PIO slave model plus a queue-based
// reference of the expected bus/event activity, checked every cycle.
module tb_pio_edge_poller;

    localparam int P = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        irq;
    logic        irq_gate;
    logic        in_port;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        event_pulse;
    logic        level;
    logic [7:0]  event_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pio_edge_poller #(
        .POLL_PERIOD(P),
        .USE_IRQ(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .irq(irq),
        .event_pulse(event_pulse),
        .level(level),
        .event_count(event_count)
    );

    // PIO slave: registered read data, falling-edge capture, write clears.
    logic [31:0] s_rdata;
    logic        s_mask;
    logic        s_ecap;
    logic        s_in_d;
    logic        s_wr;
    logic        s_rd;

    assign s_wr = avm_chipselect && !avm_write_n;
    assign s_rd = avm_chipselect && avm_write_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_rdata <= '0;
            s_mask  <= 1'b0;
            s_ecap  <= 1'b0;
            s_in_d  <= 1'b1;
        end else begin
            s_in_d <= in_port;
            if (s_wr && avm_address == 2'd2)
                s_mask <= avm_writedata[0];
            if (s_rd) begin
                case (avm_address)
                    2'd0:    s_rdata <= {31'd0, in_port};
                    2'd2:    s_rdata <= {31'd0, s_mask};
                    2'd3:    s_rdata <= {31'd0, s_ecap};
                    default: s_rdata <= '0;
                endcase
            end
            if (s_wr && avm_address == 2'd3)
                s_ecap <= 1'b0;
            else if (s_in_d && !in_port)
                s_ecap <= 1'b1;
        end
    end

    assign avm_readdata = s_rdata;
    assign irq = irq_gate & s_mask & s_ecap;

    // Reference: a queue of the bus steps still owed by the poller.
    typedef enum int {
        M_IDLE, M_INIT, M_RD3, M_WT3, M_CLR, M_RD0, M_WT0
    } step_e;

    step_e      q[$];
    step_e      m_s;
    int         idle_cnt;
    int         ev_total;
    logic [7:0] m_count;
    logic       m_level;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            q.push_back(M_INIT);
            idle_cnt = 0;
            ev_total = 0;
            m_count  = 8'd0;
            m_level  = 1'b0;
        end else if (q.size() == 0) begin
            if (enable && (idle_cnt == P - 1 || irq)) begin
                q.push_back(M_RD3);
                q.push_back(M_WT3);
                idle_cnt = 0;
            end else begin
                idle_cnt = (idle_cnt + 1) % P;
            end
        end else begin
            m_s = q.pop_front();
            case (m_s)
                M_WT3: begin
                    if (s_rdata[0])
                        q.push_back(M_CLR);
                    q.push_back(M_RD0);
                    q.push_back(M_WT0);
                end
                M_CLR: begin
                    m_count  = m_count + 8'd1;
                    ev_total = ev_total + 1;
                end
                M_WT0: m_level = s_rdata[0];
                default: ;
            endcase
        end
    end

    function automatic logic [45:0] exp_vec(
        input step_e      s,
        input logic       lv,
        input logic [7:0] cnt
    );
        logic        cs, wn, pl;
        logic [1:0]  a;
        logic [31:0] d;
        cs = 1'b0; wn = 1'b1; a = 2'd0; d = 32'd0; pl = 1'b0;
        case (s)
            M_INIT: begin cs = 1'b1; wn = 1'b0; a = 2'd2; d = 32'd1; end
            M_RD3:  begin cs = 1'b1; a = 2'd3; end
            M_CLR:  begin cs = 1'b1; wn = 1'b0; a = 2'd3; pl = 1'b1; end
            M_RD0:  begin cs = 1'b1; end
            default: ;
        endcase
        return {cs, wn, a, d, pl, lv, cnt};
    endfunction

    function automatic logic [45:0] got_vec();
        return {avm_chipselect, avm_write_n, avm_address,
                avm_writedata, event_pulse, level, event_count};
    endfunction

    task automatic tick(input string tag);
        step_e       cur;
        logic [45:0] e;
        logic [45:0] g;
        @(negedge clk);
        cur = (q.size() != 0) ? q[0] : M_IDLE;
        e = exp_vec(cur, m_level, m_count);
        g = got_vec();
        tests++;
        assert (g === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, g, e);
        end
    endtask

    task automatic check_bit(input string tag, input logic o, input logic x);
        tests++;
        assert (o === x) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, o, x);
        end
    endtask

    task automatic check_byte(
        input string tag, input logic [7:0] o, input logic [7:0] x
    );
        tests++;
        assert (o === x) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, x);
        end
    endtask

    task automatic check_reset_bus(input string tag);
        logic [45:0] e;
        e = {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 8'd0};
        tests++;
        assert (got_vec() === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got_vec(), e);
        end
    endtask

    task automatic check_init_bus(input string tag);
        logic [45:0] e;
        e = {1'b1, 1'b0, 2'd2, 32'd1, 1'b0, 1'b0, 8'd0};
        tests++;
        assert (got_vec() === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got_vec(), e);
        end
    endtask

    initial begin
        bit found;
        reset_n  = 1'b1;
        enable   = 1'b0;
        in_port  = 1'b1;
        irq_gate = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_bus("reset_state");
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1 check_init_bus("init_strobe");

        // Timer-only poll with a pending edge.
        enable  = 1'b1;
        in_port = 1'b0;
        repeat (40) tick("timer_poll");
        check_byte("timer_count", event_count, 8'd1);

        // No edge, input high: level follows, no clear.
        in_port = 1'b1;
        repeat (25) tick("no_edge");
        check_bit("level_high", level, 1'b1);

        // Edge with irq enabled.
        irq_gate = 1'b1;
        in_port  = 1'b0;
        repeat (12) tick("irq_poll");
        check_byte("irq_count", event_count, 8'd2);

        // Drop enable while reading the capture register.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick("seek_rd3");
            if (q.size() != 0 && q[0] == M_RD3)
                found = 1'b1;
        end
        check_bit("found_rd3", found, 1'b1);
        enable = 1'b0;
        repeat (30) tick("enable_low");
        check_bit("idle_cs", avm_chipselect, 1'b0);

        // Reset asserted in the middle of the clear write.
        enable   = 1'b1;
        irq_gate = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick("seek_clr");
            in_port = ~in_port;
            if (q.size() != 0 && q[0] == M_CLR)
                found = 1'b1;
        end
        check_bit("found_clr", found, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_reset_bus("reset_in_clr");
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1 check_init_bus("init_after_abort");

        // Long randomized run; enough edges to wrap the event counter.
        for (int i = 0; i < 6000; i++) begin
            tick("random");
            enable   = ($urandom_range(0, 9) != 0);
            irq_gate = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 3)
                in_port = ~in_port;
        end
        tests++;
        assert (ev_total >= 256) else begin
            fails++;
            $error("FAIL wrap_cover: observed %0d expected >=256", ev_total);
        end
        check_byte("final_count", event_count, m_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
